dff_ram_banked: RTL
===================

Name: dff_ram_banked

Overview:
- Parametrised successor to the fixed 8x72 two-bank DFF RAM.
- Flop-based RAM with configurable width, depth and bank count, and per-byte write enables.
- Registered read with a valid strobe, write-first read-during-write bypass, and a self-clearing init sequencer after reset.
- Used as a small scratch/descriptor store where SRAM macros are not worth instantiating.

Parameters:
- WIDTH, 72, data word width in bits; must be a multiple of 8.
- DEPTH, 8, total words; power of two, at least 2.
- NBANKS, 2, bank count; power of two, at least 1 and at most DEPTH.
- ADDR_W, $clog2(DEPTH), address width; localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- init_busy  output  1  high while the clear sequence runs; RAM ignores accesses.
- wr_n  input  1  active-low write strobe.
- w_addr  input  ADDR_W  write address.
- w_data  input  WIDTH  write data.
- w_be  input  WIDTH/8  byte enables; bit i covers w_data[8i+7:8i].
- rd_en  input  1  read request.
- r_addr  input  ADDR_W  read address.
- r_data  output  WIDTH  registered read data.
- r_valid  output  1  one-cycle strobe; r_data valid.
- r_perr  output  1  parity error, qualified by r_valid; tied 0 unless DFF_RAM_PARITY_EN.

Behaviour:
- Bank selection:
  - Bank = addr[ADDR_W-1 -: log2(NBANKS)]; row = remaining low bits.
  - ROWS = DEPTH/NBANKS.
  - NBANKS=1 means a single bank, all bits are row.
- Reset values: r_data=0, r_valid=0, r_perr=0, init_busy=1, FSM=INIT, init row counter=0.
- FSM states: INIT, READY.
  - INIT: each cycle, row init_row of every bank is written to all-zero (parity bits consistent).
  - INIT: counter increments; on init_row==ROWS-1, go to READY next cycle.
  - init_busy deasserts on the first READY cycle. INIT lasts exactly ROWS cycles after the reset-release edge.
  - READY: stays until rst.
- During INIT: writes dropped, reads dropped, r_valid held 0.
- rst asserted mid-operation (either state): next edge re-enters INIT with counter=0 and clears outputs. Accesses in the rst cycle are dropped.
- Write (READY, wr_n=0): bytes with w_be[i]=1 of the addressed word update at the edge; other bytes unchanged. w_be all-zero is a no-op.
- Read (READY, rd_en=1):
  - r_data = mem[r_addr] on the next edge, so latency is 1 cycle; r_valid=1 for that cycle.
  - rd_en=0: r_valid=0 next cycle and r_data holds its last value.
- Back-to-back reads every cycle give r_valid continuously high.
- Same-cycle read and write:
  - Same address: write-first. r_data = enabled new bytes merged with old bytes for disabled lanes.
  - Different addresses: fully independent, including addresses in the same bank.
- All addresses are in range by construction (power-of-two DEPTH); no error path.

Optional Feature:
- Macro DFF_RAM_PARITY_EN.
- Defined:
  - Each stored byte carries one extra even-parity bit, computed at write and generated during INIT.
  - On read, parity is recomputed. r_perr=1 together with r_valid if any byte mismatches.
  - Bypassed write-first data never flags.
- Undefined:
  - No parity storage.
  - r_perr is constant 0; port list is unchanged.

Decomposition:
- Package dff_ram_pkg holds:
  - BYTE_W=8.
  - fsm state enum (INIT, READY).
  - function byte_parity(WIDTH-wide word) returning a per-byte parity vector.
  - helper for bank/row split widths.
- Sub-module dff_ram_bank (params WIDTH, ROWS): one bank of flops with byte-masked write and combinational read.
  - Instantiated NBANKS times via generate.
  - Top owns the FSM, bank decode, bypass mux and output registers.

Test Plan:
- Reset and init (DEPTH=8, NBANKS=2): deassert rst → init_busy high exactly 4 cycles; then read all 8 addresses → r_data=0, r_valid 1 cycle after each rd_en.
- Full write/read: write addr k with data {9{8'hk0+k}}, w_be all-ones, k=0..7 → readback matches per address, across both banks.
- Byte mask: write addr 3 with 72'hFF.., then write 72'h00.. with w_be=9'b0_0000_0101 → read addr 3 returns bytes 0 and 2 = 00, others FF.
- Write-first collision: addr 5 holds 72'h11..; same cycle write 72'h22.., w_be=all, and read addr 5 → r_data=72'h22.. next cycle. Same with w_be=0 → 72'h11...
- Reset mid-traffic: write addr 6, assert rst one cycle during a read → r_valid=0 next cycle, init_busy reasserts, addr 6 reads 0 after init. Also repeat with DEPTH=16, NBANKS=4 (4 init cycles).
- Parity (DFF_RAM_PARITY_EN): write addr 2, force-flip one stored data bit hierarchically, read addr 2 → r_perr=1 with r_valid. Unflipped addr reads r_perr=0. Macro undefined → r_perr always 0.

Source files
------------

// File: rtl/dff_ram_pkg.sv
// Shared types and helpers for the banked flop RAM.
package dff_ram_pkg;

  localparam int BYTE_W = 8;
  // Widest word the parity helper handles; callers zero-extend into it.
  localparam int MAX_W  = 1024;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } fsm_state_e;

  // Even parity of every byte of a (zero-extended) word, one bit per byte.
  function automatic logic [MAX_W/BYTE_W-1:0] byte_parity(input logic [MAX_W-1:0] word);
    logic [MAX_W/BYTE_W-1:0] par;
    par = '0;
    for (int i = 0; i < MAX_W/BYTE_W; i++) begin
      par[i] = ^word[i*BYTE_W +: BYTE_W];
    end
    return par;
  endfunction

  // Number of address bits that select the bank.
  function automatic int bank_bits(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 0;
  endfunction

  // Declared width for an address field that may legitimately be zero bits.
  function automatic int field_w(input int bits);
    return (bits > 0) ? bits : 1;
  endfunction

endpackage

// File: rtl/dff_ram_bank.sv
// One bank of flop storage: lane-masked synchronous write, combinational read.
// A lane is one byte, or one byte plus its parity bit when parity is stored.
module dff_ram_bank
  import dff_ram_pkg::*;
#(
  parameter int  WIDTH  = 72,
  parameter int  ROWS   = 4,
  parameter int  LANE_W = 8,
  localparam int LANES  = WIDTH / LANE_W,
  localparam int ROW_W  = field_w($clog2(ROWS))
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ROW_W-1:0]  w_row_i,
  input  logic [WIDTH-1:0]  w_data_i,
  input  logic [LANES-1:0]  w_be_i,
  input  logic [ROW_W-1:0]  r_row_i,
  output logic [WIDTH-1:0]  r_data_o
);

  logic [WIDTH-1:0] mem_q [ROWS];

  // Update only the enabled lanes of the addressed row.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_be_i[i]) begin
          mem_q[w_row_i][i*LANE_W +: LANE_W] <= w_data_i[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign r_data_o = mem_q[r_row_i];

endmodule

// File: rtl/dff_ram_banked.sv
// Banked flop RAM with byte enables, registered read, write-first bypass and
// a clear sequencer that zeroes every row after reset.
// Optional feature macro: DFF_RAM_PARITY_EN (per-byte even parity on storage).
module dff_ram_banked
  import dff_ram_pkg::*;
#(
  parameter int  WIDTH  = 72,
  parameter int  DEPTH  = 8,
  parameter int  NBANKS = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_n,
  input  logic [ADDR_W-1:0]       w_addr,
  input  logic [WIDTH-1:0]        w_data,
  input  logic [WIDTH/BYTE_W-1:0] w_be,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       r_addr,
  output logic [WIDTH-1:0]        r_data,
  output logic                    r_valid,
  output logic                    r_perr
);

  localparam int NBYTES    = WIDTH / BYTE_W;
  localparam int ROWS      = DEPTH / NBANKS;
  localparam int BANK_BITS = bank_bits(NBANKS);
  localparam int ROW_BITS  = ADDR_W - BANK_BITS;
  localparam int BANK_W    = field_w(BANK_BITS);
  localparam int ROW_W     = field_w(ROW_BITS);
`ifdef DFF_RAM_PARITY_EN
  localparam int LANE_W    = BYTE_W + 1;
`else
  localparam int LANE_W    = BYTE_W;
`endif
  localparam int STORE_W   = NBYTES * LANE_W;

  fsm_state_e         state_q;
  logic [ROW_W-1:0]   init_row_q;
  logic               init_busy_q;

  logic [WIDTH-1:0]   r_data_q,  r_data_d;
  logic               r_valid_q, r_valid_d;
  logic               r_perr_q,  r_perr_d;

  logic [BANK_W-1:0]  w_bank_s, r_bank_s;
  logic [ROW_W-1:0]   w_row_s,  r_row_s;

  logic               init_acc_s, write_acc_s, read_acc_s, hit_s;
  logic [NBANKS-1:0]  bank_we_s;
  logic [ROW_W-1:0]   wr_row_mux_s;
  logic [STORE_W-1:0] wr_data_mux_s, store_wdata_s;
  logic [NBYTES-1:0]  wr_be_mux_s;
  logic [STORE_W-1:0] bank_rdata_s [NBANKS];
  logic [STORE_W-1:0] rd_store_s;
  logic [WIDTH-1:0]   rd_old_s, rd_merge_s;
  logic               perr_s;

  // Address split: bank from the top bits, row from the rest.
  if (BANK_BITS > 0) begin : gen_bank_sel
    assign w_bank_s = w_addr[ADDR_W-1 -: BANK_BITS];
    assign r_bank_s = r_addr[ADDR_W-1 -: BANK_BITS];
  end else begin : gen_single_bank
    assign w_bank_s = '0;
    assign r_bank_s = '0;
  end

  if (ROW_BITS > 0) begin : gen_row_sel
    assign w_row_s = w_addr[ROW_BITS-1:0];
    assign r_row_s = r_addr[ROW_BITS-1:0];
  end else begin : gen_single_row
    assign w_row_s = '0;
    assign r_row_s = '0;
  end

  assign init_acc_s  = (state_q == ST_INIT)  && !rst;
  assign write_acc_s = (state_q == ST_READY) && !rst && !wr_n;
  assign read_acc_s  = (state_q == ST_READY) && !rst && rd_en;
  assign hit_s       = write_acc_s && (w_addr == r_addr);

  // Pack write data into storage lanes, appending parity when stored.
  always_comb begin
    store_wdata_s = '0;
`ifdef DFF_RAM_PARITY_EN
    begin
      logic [NBYTES-1:0] wr_par_v;
      wr_par_v = NBYTES'(byte_parity(MAX_W'(w_data)));
      for (int i = 0; i < NBYTES; i++) begin
        store_wdata_s[i*LANE_W +: BYTE_W] = w_data[i*BYTE_W +: BYTE_W];
        store_wdata_s[i*LANE_W + BYTE_W]  = wr_par_v[i];
      end
    end
`else
    for (int i = 0; i < NBYTES; i++) begin
      store_wdata_s[i*LANE_W +: BYTE_W] = w_data[i*BYTE_W +: BYTE_W];
    end
`endif
  end

  // Bank write port: clear sequencer hits every bank, user writes hit one.
  always_comb begin
    bank_we_s     = '0;
    wr_row_mux_s  = w_row_s;
    wr_data_mux_s = store_wdata_s;
    wr_be_mux_s   = w_be;
    if (init_acc_s) begin
      bank_we_s     = '1;
      wr_row_mux_s  = init_row_q;
      wr_data_mux_s = '0;
      wr_be_mux_s   = '1;
    end else if (write_acc_s) begin
      bank_we_s[w_bank_s] = 1'b1;
    end else begin
      bank_we_s = '0;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : gen_bank
    dff_ram_bank #(
      .WIDTH  (STORE_W),
      .ROWS   (ROWS),
      .LANE_W (LANE_W)
    ) u_bank (
      .clk      (clk),
      .we_i     (bank_we_s[b]),
      .w_row_i  (wr_row_mux_s),
      .w_data_i (wr_data_mux_s),
      .w_be_i   (wr_be_mux_s),
      .r_row_i  (r_row_s),
      .r_data_o (bank_rdata_s[b])
    );
  end

  // Read path: select bank, unpack, merge same-address write bytes, check parity.
  always_comb begin
    rd_store_s = bank_rdata_s[r_bank_s];
    rd_old_s   = '0;
    rd_merge_s = '0;
    perr_s     = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      rd_old_s[i*BYTE_W +: BYTE_W] = rd_store_s[i*LANE_W +: BYTE_W];
      if (hit_s && w_be[i]) begin
        rd_merge_s[i*BYTE_W +: BYTE_W] = w_data[i*BYTE_W +: BYTE_W];
      end else begin
        rd_merge_s[i*BYTE_W +: BYTE_W] = rd_store_s[i*LANE_W +: BYTE_W];
      end
    end
`ifdef DFF_RAM_PARITY_EN
    begin
      logic [NBYTES-1:0] rd_par_v;
      for (int i = 0; i < NBYTES; i++) begin
        rd_par_v[i] = rd_store_s[i*LANE_W + BYTE_W];
      end
      perr_s = |(rd_par_v ^ NBYTES'(byte_parity(MAX_W'(rd_old_s))));
    end
`endif
  end

  // Next values of the read output registers; r_data holds when idle.
  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    r_perr_d  = 1'b0;
    if (read_acc_s) begin
      r_data_d  = rd_merge_s;
      r_valid_d = 1'b1;
      r_perr_d  = perr_s && !hit_s;
    end else begin
      r_valid_d = 1'b0;
      r_perr_d  = 1'b0;
    end
  end

  // Read output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      r_perr_q  <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      r_perr_q  <= r_perr_d;
    end
  end

  // Clear sequencer: walk every row once after reset, then serve accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_row_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_row_q == ROW_W'(ROWS - 1)) begin
            state_q     <= ST_READY;
            init_row_q  <= '0;
            init_busy_q <= 1'b0;
          end else begin
            init_row_q  <= init_row_q + ROW_W'(1);
          end
        end
        ST_READY: begin
          state_q     <= ST_READY;
          init_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_INIT;
          init_row_q  <= '0;
          init_busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign init_busy = init_busy_q;
  assign r_data    = r_data_q;
  assign r_valid   = r_valid_q;
  assign r_perr    = r_perr_q;

endmodule
